// File: rtl/uart_sched_pkg.sv
// Shared definitions for the two-requester UART transmit scheduler.
package uart_sched_pkg;

  localparam int unsigned RISE_TIMEOUT_DEF = 8;
  localparam int unsigned LOCK_TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_RISE = 2'd2,
    ST_WAIT_FALL = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; a held message lock restricts the pick to its owner.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       locked,
  input  logic       owner,
  input  logic       last_grant,
  output logic       grant_c,
  output logic       winner_c
);

  always_comb begin
    grant_c  = 1'b0;
    winner_c = last_grant;
    if (locked) begin
      grant_c  = req[owner];
      winner_c = owner;
    end else if (req == 2'b11) begin
      grant_c  = 1'b1;
      winner_c = ~last_grant;
    end else if (req[0]) begin
      grant_c  = 1'b1;
      winner_c = 1'b0;
    end else if (req[1]) begin
      grant_c  = 1'b1;
      winner_c = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules bytes from two requesters onto one UART transmitter, holding the
// transmitter for multi-byte messages and aborting launches that never go busy.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned RISE_TIMEOUT = RISE_TIMEOUT_DEF,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       last0,
  input  logic       last1,
  output logic       ack0,
  output logic       ack1,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       owner,
  output logic       locked,
  output logic       err
);

  localparam int unsigned RISE_W = $clog2(RISE_TIMEOUT + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [RISE_W-1:0] RISE_LAST = RISE_W'(RISE_TIMEOUT - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);

  state_e            state;
  logic [RISE_W-1:0] rise_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic              last_grant;
  logic              last_q;
  logic              grant_c;
  logic              winner_c;
  logic [7:0]        win_data_c;
  logic              win_last_c;
  logic              owner_req_c;

  rr_arb2 u_arb (
    .req        ({req1, req0}),
    .locked     (locked),
    .owner      (owner),
    .last_grant (last_grant),
    .grant_c    (grant_c),
    .winner_c   (winner_c)
  );

  assign win_data_c  = winner_c ? data1 : data0;
  assign win_last_c  = winner_c ? last1 : last0;
  assign owner_req_c = owner ? req1 : req0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      owner      <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      last_grant <= 1'b1;
      last_q     <= 1'b0;
      rise_cnt   <= '0;
      lock_cnt   <= '0;
    end else begin
      tx_start <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!tx_busy && grant_c) begin
            tx_data    <= win_data_c;
            owner      <= winner_c;
            last_grant <= winner_c;
            last_q     <= win_last_c;
            ack0       <= ~winner_c;
            ack1       <= winner_c;
            tx_start   <= 1'b1;
            lock_cnt   <= '0;
            state      <= ST_LAUNCH;
          end else if (locked && !owner_req_c) begin
            // Owner went quiet mid-message: release the lock after a bounded wait.
            if (lock_cnt == LOCK_LAST) begin
              locked   <= 1'b0;
              lock_cnt <= '0;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end
        end
        ST_LAUNCH: begin
          rise_cnt <= '0;
          state    <= ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          if (tx_busy) begin
            state <= ST_WAIT_FALL;
          end else begin
            rise_cnt <= rise_cnt + 1'b1;
            if (rise_cnt == RISE_LAST) begin
              err      <= 1'b1;
              locked   <= 1'b0;
              lock_cnt <= '0;
              state    <= ST_IDLE;
            end
          end
        end
        ST_WAIT_FALL: begin
          if (!tx_busy) begin
            locked   <= ~last_q;
            lock_cnt <= '0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scheduler driving a behavioural UART transmitter; serial line decoded and scoreboarded.
module tb_uart_tx_sched;

  localparam int unsigned RISE_TIMEOUT = 8;
  localparam int unsigned LOCK_TIMEOUT = 1024;
  localparam int unsigned BAUD         = 8;

  typedef struct packed {
    logic       owner;
    logic [7:0] data;
    logic       locked;
  } gexp_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } byte_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       last0 = 1'b0, last1 = 1'b0;
  logic       ack0, ack1, tx_start, owner, locked, err;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       kill = 1'b0;

  uart_tx_sched #(.RISE_TIMEOUT(RISE_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .last0(last0), .last1(last1), .ack0(ack0), .ack1(ack1),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .owner(owner), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural UART transmitter: 8N1, BAUD clocks per bit
  logic       busy_m = 1'b0;
  logic [9:0] sh_m = 10'h3FF;
  int         div_m = 0, bit_m = 0;
  logic       line;
  assign line    = busy_m ? sh_m[0] : 1'b1;
  assign tx_busy = busy_m & ~kill;

  always @(posedge clk) begin
    if (!busy_m) begin
      if (tx_start && !kill) begin
        busy_m <= 1'b1;
        sh_m   <= {1'b1, tx_data, 1'b0};
        div_m  <= 0;
        bit_m  <= 0;
      end
    end else if (div_m == BAUD - 1) begin
      div_m <= 0;
      sh_m  <= {1'b1, sh_m[9:1]};
      bit_m <= bit_m + 1;
      if (bit_m == 9) busy_m <= 1'b0;
    end else begin
      div_m <= div_m + 1;
    end
  end

  // Serial receiver sampling mid-bit
  logic       rx_act = 1'b0;
  int         rx_cnt = 0, rx_bit = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (!rx_act) begin
      if (!line) begin
        rx_act <= 1'b1;
        rx_cnt <= BAUD + BAUD / 2 - 1;
        rx_bit <= 0;
      end
    end else if (rx_cnt == 0) begin
      if (rx_bit == 8) begin
        rx_act <= 1'b0;
        if (line) rx_q.push_back(rx_sh);
      end else begin
        rx_sh <= {line, rx_sh[7:1]};
      end
      rx_bit <= rx_bit + 1;
      rx_cnt <= BAUD - 1;
    end else begin
      rx_cnt <= rx_cnt - 1;
    end
  end

  int         n_chk = 0, n_pass = 0;
  gexp_t      exp_g[$];
  logic [7:0] exp_rx[$];
  byte_t      q0[$], q1[$];
  logic [7:0] prev_txd = 8'h00;
  logic       prev_locked = 1'b0;
  logic       err_ok = 1'b0;
  int         start_cyc = 0, err_cyc = -1, lock_rise = 0, lock_fall = 0, n_starts = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive();
    req0 = (q0.size() != 0);
    req1 = (q1.size() != 0);
    if (req0) begin data0 = q0[0].data; last0 = q0[0].last; end
    if (req1) begin data1 = q1[0].data; last1 = q1[0].last; end
  endtask

  // One clock: observe at the falling edge, score, then update requesters
  task automatic step();
    gexp_t g;
    logic [7:0] r;
    @(negedge clk);
    if (!rst && tx_data !== prev_txd && tx_start !== 1'b1) chk("txd_hold", tx_data, prev_txd);
    prev_txd = tx_data;
    if (tx_start === 1'b1) begin
      n_starts++;
      start_cyc = cyc;
      if (exp_g.size() == 0) chk("spurious_start", tx_start, 0);
      else begin
        g = exp_g.pop_front();
        chk("tx_data", tx_data, g.data);
        chk("owner", owner, g.owner);
        chk("locked_at_start", locked, g.locked);
        chk("ack0", ack0, !g.owner);
        chk("ack1", ack1, g.owner);
      end
    end else if (ack0 === 1'b1 || ack1 === 1'b1) begin
      chk("ack_without_start", {ack1, ack0}, 2'b00);
    end
    if (err === 1'b1) begin
      err_cyc = cyc;
      if (!err_ok) chk("err_unexpected", err, 0);
    end
    if (locked === 1'b1 && prev_locked !== 1'b1) lock_rise = cyc;
    if (locked === 1'b0 && prev_locked === 1'b1) lock_fall = cyc;
    prev_locked = locked;
    while (rx_q.size() != 0) begin
      r = rx_q.pop_front();
      if (exp_rx.size() == 0) chk("rx_extra", {1'b0, r}, 9'h1FF);
      else chk("rx_byte", r, exp_rx.pop_front());
    end
    if (ack0 === 1'b1 && q0.size() != 0) void'(q0.pop_front());
    if (ack1 === 1'b1 && q1.size() != 0) void'(q1.pop_front());
    drive();
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_g.size() != 0 ||
            exp_rx.size() != 0 || tx_busy) && n < max) begin
      step();
      n++;
    end
    chk({tag, "_done"}, (n < max), 1'b1);
  endtask

  function automatic gexp_t ge(input logic o, input logic [7:0] d, input logic l);
    ge.owner = o; ge.data = d; ge.locked = l;
  endfunction

  function automatic byte_t by(input logic [7:0] d, input logic l);
    by.data = d; by.last = l;
  endfunction

  initial begin
    int n;
    // Reset values
    rst = 1'b1;
    step(); step();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_ack", {ack1, ack0}, 2'b00);
    chk("rst_owner", owner, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    step();

    // Single byte from requester 0
    q0.push_back(by(8'h41, 1'b1));
    exp_g.push_back(ge(1'b0, 8'h41, 1'b0));
    exp_rx.push_back(8'h41);
    drive();
    wait_done("single", 600);
    step(); step();
    chk("single_unlocked", locked, 0);

    // Simultaneous requests right after reset: requester 0 first
    rst = 1'b1; step(); rst = 1'b0; step();
    q0.push_back(by(8'h30, 1'b1));
    q1.push_back(by(8'h31, 1'b1));
    exp_g.push_back(ge(1'b0, 8'h30, 1'b0));
    exp_g.push_back(ge(1'b1, 8'h31, 1'b0));
    exp_rx.push_back(8'h30);
    exp_rx.push_back(8'h31);
    drive();
    wait_done("simul", 1000);

    // Locked three-byte message blocks the other requester, which then wins
    q0.push_back(by(8'h31, 1'b0));
    q0.push_back(by(8'h32, 1'b0));
    q0.push_back(by(8'h3A, 1'b1));
    q1.push_back(by(8'h58, 1'b1));
    exp_g.push_back(ge(1'b0, 8'h31, 1'b0));
    exp_g.push_back(ge(1'b0, 8'h32, 1'b1));
    exp_g.push_back(ge(1'b0, 8'h3A, 1'b1));
    exp_g.push_back(ge(1'b1, 8'h58, 1'b0));
    foreach (exp_g[i]) exp_rx.push_back(exp_g[i].data);
    drive();
    wait_done("message", 2000);
    step(); step();
    chk("message_unlocked", locked, 0);

    // Owner abandons message: other requester waits out the lock timeout
    q0.push_back(by(8'h55, 1'b0));
    exp_g.push_back(ge(1'b0, 8'h55, 1'b0));
    exp_rx.push_back(8'h55);
    drive();
    wait_done("lock_first", 600);
    step(); step();
    chk("lock_held", locked, 1);
    q1.push_back(by(8'h66, 1'b1));
    exp_g.push_back(ge(1'b1, 8'h66, 1'b0));
    exp_rx.push_back(8'h66);
    drive();
    wait_done("lock_second", 3000);
    chk("lock_hold_cycles", lock_fall - lock_rise, LOCK_TIMEOUT);
    chk("lock_grant_cycle", start_cyc - lock_rise, LOCK_TIMEOUT + 1);

    // Transmitter never goes busy: abort with err
    kill = 1'b1;
    err_ok = 1'b1;
    err_cyc = -1;
    q0.push_back(by(8'h77, 1'b1));
    exp_g.push_back(ge(1'b0, 8'h77, 1'b0));
    drive();
    n = 0;
    while (err_cyc < 0 && n < 60) begin step(); n++; end
    chk("err_seen", (err_cyc >= 0), 1'b1);
    chk("err_latency", err_cyc - start_cyc, RISE_TIMEOUT + 1);
    step();
    chk("err_one_cycle", err, 0);
    chk("err_unlocked", locked, 0);
    err_ok = 1'b0;
    repeat (20) step();
    kill = 1'b0;
    q0.push_back(by(8'h4B, 1'b1));
    exp_g.push_back(ge(1'b0, 8'h4B, 1'b0));
    exp_rx.push_back(8'h4B);
    drive();
    wait_done("after_err", 600);

    // Reset while waiting for the transmitter to finish
    q1.push_back(by(8'h5A, 1'b1));
    exp_g.push_back(ge(1'b1, 8'h5A, 1'b0));
    exp_rx.push_back(8'h5A);
    drive();
    n = n_starts;
    while (n_starts == n && exp_g.size() != 0) step();
    repeat (12) step();
    rst = 1'b1;
    step();
    chk("mid_rst_tx_start", tx_start, 0);
    chk("mid_rst_tx_data", tx_data, 8'h00);
    chk("mid_rst_ack", {ack1, ack0}, 2'b00);
    chk("mid_rst_owner", owner, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_err", err, 0);
    rst = 1'b0;
    step();
    chk("post_rst_tx_start", tx_start, 0);
    chk("post_rst_ack", {ack1, ack0}, 2'b00);
    wait_done("post_rst", 600);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
